// File: rtl/network_top_sdiv_24s_12s_24_seq.sv
`default_nettype none
// ============================================================================
// Module   : network_top_sdiv_24s_12s_24_seq
// Brief    : Radix-2 restoring signed divider, 24s / 12s -> 24s quotient,
//            12s remainder, one quotient bit per enabled clock.
// Revision : 1.0  initial release
// ============================================================================
module network_top_sdiv_24s_12s_24_seq #(
   parameter int ID         = 1,
   parameter int NUM_STAGE  = 25,
   parameter int din0_WIDTH = 24,
   parameter int din1_WIDTH = 12,
   parameter int dout_WIDTH = 24
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  ce,
   input  logic                  start,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  busy,
   output logic                  done,
   output logic [dout_WIDTH-1:0] quot,
   output logic [din1_WIDTH-1:0] rem,
   output logic                  dbz
);

   localparam int CNT_W = $clog2(NUM_STAGE);
   localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(din0_WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   // Dividend magnitude shifts out MSB-first while quotient bits shift in.
   logic [din0_WIDTH-1:0] mag_a_q, mag_a_d;
   logic [din1_WIDTH-1:0] mag_b_q, mag_b_d;
   logic [din1_WIDTH-1:0] pr_q, pr_d;
   logic                  neg_quot_q, neg_quot_d;
   logic                  neg_rem_q, neg_rem_d;
   logic                  dbz_n_q, dbz_n_d;
   logic [din1_WIDTH-1:0] din_lo_q, din_lo_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [dout_WIDTH-1:0] quot_q, quot_d;
   logic [din1_WIDTH-1:0] rem_q, rem_d;
   logic                  dbz_q, dbz_d;

   logic                  w_accept;
   logic                  w_step;
   logic                  w_fix;

   logic [din1_WIDTH:0]   w_shifted;
   logic [din1_WIDTH:0]   w_diff;
   logic                  w_ge;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (ce && start)                  state_d = S_CALC;
         S_CALC: if (ce && cnt_q == C_LAST_ITER)   state_d = S_FIX;
         S_FIX:  if (ce)                           state_d = S_IDLE;
         default:                                  state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Control strobes decoded from state
   // ------------------------------------------------------------------------
   always_comb begin
      w_accept = 1'b0;
      w_step   = 1'b0;
      w_fix    = 1'b0;
      case (state_q)
         S_IDLE:  w_accept = ce & start;
         S_CALC:  w_step   = ce;
         S_FIX:   w_fix    = ce;
         default: ;
      endcase
   end

   // Trial subtract is one bit wider than the divisor so it cannot overflow.
   always_comb begin
      w_shifted = {pr_q, mag_a_q[din0_WIDTH-1]};
      w_diff    = w_shifted - {1'b0, mag_b_q};
      w_ge      = (w_shifted >= {1'b0, mag_b_q});
   end

   // ------------------------------------------------------------------------
   // Datapath next values
   // ------------------------------------------------------------------------
   always_comb begin
      cnt_d      = cnt_q;
      mag_a_d    = mag_a_q;
      mag_b_d    = mag_b_q;
      pr_d       = pr_q;
      neg_quot_d = neg_quot_q;
      neg_rem_d  = neg_rem_q;
      dbz_n_d    = dbz_n_q;
      din_lo_d   = din_lo_q;
      busy_d     = busy_q;
      done_d     = ce ? 1'b0 : done_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      dbz_d      = dbz_q;

      if (w_accept) begin
         cnt_d      = '0;
         mag_a_d    = din0[din0_WIDTH-1] ? (~din0 + 1'b1) : din0;
         mag_b_d    = din1[din1_WIDTH-1] ? (~din1 + 1'b1) : din1;
         pr_d       = '0;
         neg_quot_d = din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
         neg_rem_d  = din0[din0_WIDTH-1];
         dbz_n_d    = (din1 == '0);
         din_lo_d   = din0[din1_WIDTH-1:0];
         busy_d     = 1'b1;
      end

      if (w_step) begin
         cnt_d   = cnt_q + 1'b1;
         pr_d    = w_ge ? w_diff[din1_WIDTH-1:0] : w_shifted[din1_WIDTH-1:0];
         mag_a_d = {mag_a_q[din0_WIDTH-2:0], w_ge};
      end

      if (w_fix) begin
         busy_d = 1'b0;
         done_d = 1'b1;
         dbz_d  = dbz_n_q;
         if (dbz_n_q) begin
            quot_d = '1;
            rem_d  = din_lo_q;
         end else begin
            quot_d = neg_quot_q ? (~mag_a_q + 1'b1) : mag_a_q;
            rem_d  = neg_rem_q  ? (~pr_q + 1'b1)    : pr_q;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         cnt_q      <= '0;
         mag_a_q    <= '0;
         mag_b_q    <= '0;
         pr_q       <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         dbz_n_q    <= 1'b0;
         din_lo_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         quot_q     <= '0;
         rem_q      <= '0;
         dbz_q      <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         mag_a_q    <= mag_a_d;
         mag_b_q    <= mag_b_d;
         pr_q       <= pr_d;
         neg_quot_q <= neg_quot_d;
         neg_rem_q  <= neg_rem_d;
         dbz_n_q    <= dbz_n_d;
         din_lo_q   <= din_lo_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
         dbz_q      <= dbz_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign quot = quot_q;
   assign rem  = rem_q;
   assign dbz  = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_network_top_sdiv_24s_12s_24_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_network_top_sdiv_24s_12s_24_seq
// Brief    : Self-checking bench for the sequential 24s/12s signed divider.
// Revision : 1.0  initial release
// ============================================================================
module tb_network_top_sdiv_24s_12s_24_seq;

   logic        ap_clk = 1'b0;
   logic        ap_rst;
   logic        ce;
   logic        start;
   logic [23:0] din0;
   logic [11:0] din1;
   logic        busy;
   logic        done;
   logic [23:0] quot;
   logic [11:0] rem;
   logic        dbz;

   int checks = 0;
   int errors = 0;

   network_top_sdiv_24s_12s_24_seq #(
      .ID(1), .NUM_STAGE(25), .din0_WIDTH(24), .din1_WIDTH(12), .dout_WIDTH(24)
   ) dut (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
      .ce     (ce),
      .start  (start),
      .din0   (din0),
      .din1   (din1),
      .busy   (busy),
      .done   (done),
      .quot   (quot),
      .rem    (rem),
      .dbz    (dbz)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // C-style signed division: truncation toward zero, remainder follows dividend.
   function automatic void model(input logic [23:0] a, input logic [11:0] b,
                                 output logic [23:0] q, output logic [11:0] r,
                                 output logic d);
      int sa;
      int sb;
      sa = {{8{a[23]}}, a};
      sb = {{20{b[11]}}, b};
      if (sb == 0) begin
         q = 24'hFFFFFF;
         r = a[11:0];
         d = 1'b1;
      end else begin
         q = 24'(sa / sb);
         r = 12'(sa % sb);
         d = 1'b0;
      end
   endfunction

   task automatic issue(input logic [23:0] a, input logic [11:0] b);
      @(negedge ap_clk);
      din0  = a;
      din1  = b;
      start = 1'b1;
      ce    = 1'b1;
      @(posedge ap_clk);
      #1;
      chk("accept_busy", busy, 1);
      chk("accept_done", done, 0);
   endtask

   task automatic wait_result(input logic [23:0] a, input logic [11:0] b,
                              input bit rand_ce, input bit hold);
      logic [23:0] eq;
      logic [11:0] er;
      logic        ed;
      int          n;
      int          cyc;
      bit          got;
      model(a, b, eq, er, ed);
      n   = 0;
      cyc = 0;
      got = 0;
      while (!got && cyc < 200) begin
         @(negedge ap_clk);
         ce    = rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;
         start = hold;
         if (hold) begin
            din0 = 24'($urandom);
            din1 = 12'($urandom);
         end
         @(posedge ap_clk);
         if (ce) n++;
         cyc++;
         #1;
         if (done) got = 1;
         else chk("busy_mid", busy, 1);
      end
      chk("timeout", 32'(got), 1);
      chk("latency", n, 25);
      chk("quot", quot, eq);
      chk("rem", rem, er);
      chk("dbz", dbz, ed);
      chk("busy_at_done", busy, 0);
   endtask

   initial begin
      logic [23:0] da[10];
      logic [11:0] db[10];
      logic [23:0] ra;
      logic [11:0] rb;

      da = '{24'd100, 24'(-100), 24'd100, 24'(-100), 24'(-2048),
             24'h800000, 24'h7FFFFF, 24'd5, 24'd1234, 24'd9};
      db = '{12'd7, 12'd7, 12'(-7), 12'(-7), 12'(-2048),
             12'hFFF, 12'd1, 12'd2047, 12'd0, 12'd3};

      ap_rst = 1'b1;
      ce     = 1'b0;
      start  = 1'b1;
      din0   = 24'd100;
      din1   = 12'd7;
      repeat (3) @(posedge ap_clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_quot", quot, 0);
      chk("rst_rem", rem, 0);
      chk("rst_dbz", dbz, 0);
      @(negedge ap_clk);
      ap_rst = 1'b0;
      start  = 1'b0;
      ce     = 1'b1;

      for (int i = 0; i < 10; i++) begin
         issue(da[i], db[i]);
         wait_result(da[i], db[i], 1'b0, 1'b0);
      end

      // done must hold across a stalled cycle, then drop on the next enabled edge
      @(negedge ap_clk);
      ce    = 1'b0;
      start = 1'b0;
      @(posedge ap_clk);
      #1;
      chk("done_hold_ce0", done, 1);
      @(negedge ap_clk);
      ce = 1'b1;
      @(posedge ap_clk);
      #1;
      chk("done_fall", done, 0);
      chk("quot_hold", quot, 24'd3);

      // start held high with changing operands: one result, then a fresh accept
      issue(24'd1000, 12'd9);
      wait_result(24'd1000, 12'd9, 1'b0, 1'b1);
      issue(24'(-777), 12'd5);
      wait_result(24'(-777), 12'd5, 1'b0, 1'b0);

      for (int i = 0; i < 30; i++) begin
         ra = 24'($urandom);
         if ($urandom_range(0, 3) == 0) rb = 12'($urandom_range(0, 8)) - 12'd4;
         else rb = 12'($urandom);
         issue(ra, rb);
         wait_result(ra, rb, 1'b1, 1'b0);
      end

      // reset during iteration 10 discards the operation
      issue(24'd100, 12'd7);
      for (int i = 0; i < 10; i++) begin
         @(negedge ap_clk);
         ce    = 1'b1;
         start = 1'b0;
         @(posedge ap_clk);
      end
      @(negedge ap_clk);
      ap_rst = 1'b1;
      @(posedge ap_clk);
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_quot", quot, 0);
      chk("midrst_rem", rem, 0);
      chk("midrst_dbz", dbz, 0);
      @(negedge ap_clk);
      ap_rst = 1'b0;
      issue(24'd50, 12'd5);
      wait_result(24'd50, 12'd5, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/network_top_sdiv_24s_12s_24_seq.md
# network_top_sdiv_24s_12s_24_seq

Sequential signed divider that reverses the 12s×12s→24 product path. It divides a 24-bit signed accumulator/product by a 12-bit signed scale and returns a 24-bit quotient and a 12-bit remainder. It sits after the MAC stage in `network_top` for normalisation and rescaling. It is a radix-2 restoring divider: one quotient bit per clock, start/done handshake, clock-enable stall.

## Interface
Parameters:
- ID, 1, instance tag; no functional effect
- NUM_STAGE, 25, accept-to-done latency in clock edges; informational only, not a configurable
- din0_WIDTH, 24, dividend width
- din1_WIDTH, 12, divisor width; also the remainder width
- dout_WIDTH, 24, quotient width; must equal din0_WIDTH

Ports:
- ap_clk  in  1  clock; all state changes on the rising edge
- ap_rst  in  1  reset; synchronous, active-high
- ce  in  1  clock enable; when 0, all state, counters and outputs hold
- start  in  1  request; sampled only when ce=1 and the block is idle
- din0  in  din0_WIDTH  signed dividend; captured at start accept
- din1  in  din1_WIDTH  signed divisor; captured at start accept
- busy  out  1  high from the accept edge until done is asserted
- done  out  1  one-cycle pulse; quot, rem and dbz are valid while done=1
- quot  out  dout_WIDTH  signed quotient
- rem  out  din1_WIDTH  signed remainder
- dbz  out  1  divide-by-zero flag for the current result

## Operation
- States: IDLE, CALC, FIX.
- Reset (ap_rst=1 at an edge, regardless of ce):
  - state=IDLE
  - busy=0, done=0, dbz=0
  - quot=0, rem=0
  - iteration counter=0
  - any in-flight operation is discarded with no done pulse
- IDLE: on start=1 & ce=1, capture the following and go to CALC with busy=1:
  - |din0| into a 24-bit magnitude register
  - |din1| into a 12-bit magnitude register
  - sign_q = din0[MSB]^din1[MSB]
  - sign_r = din0[MSB]
  - dbz_n = (din1==0)
- Magnitude widths:
  - |−2^23| is held as an unsigned 24-bit value 0x800000.
  - |−2^11| is held as 0x800 in 12 bits.
  - The partial remainder is 13 bits wide, so the trial subtract never overflows.
- CALC, one iteration per ce=1 edge, 24 iterations, MSB first:
  - Shift the partial remainder left by one, bringing in the next dividend bit.
  - If partial remainder ≥ divisor magnitude: subtract and shift 1 into the quotient; otherwise shift 0.
  - After the 24th iteration, go to FIX.
- FIX, one ce=1 edge:
  - quot = sign_q ? −Q : Q, truncated to 24 bits (C semantics, truncation toward zero).
  - rem = sign_r ? −R : R, so the remainder takes the sign of the dividend.
  - dbz = dbz_n.
  - done=1, busy=0, state=IDLE.
- Overflow: −8388608 / −1 wraps to quot=−8388608 (0x800000), rem=0, no flag.
- Divide by zero:
  - The iterations still run; the result is forced in FIX.
  - quot=0xFFFFFF, rem=din0[11:0] as captured, dbz=1.
- Outputs hold their last result until the next FIX or reset; only done returns to 0.
- start while busy=1 is ignored; no queuing, no error.
- din0/din1 changes after the accept edge have no effect.

## Timing
- The accept edge is E0.
- busy=1 is visible after E0.
- CALC iterations occur on edges E1..E24 (ce=1 edges only).
- FIX occurs on E25; after E25, done=1 and busy=0 for exactly one cycle.
- Latency is NUM_STAGE=25 ce-qualified edges.
- ce=0 cycles stretch latency one-for-one. If ce=0 while done=1, done stays high until the next ce=1 edge.
- Back-to-back: start=1 during the done cycle is accepted at the next edge. Maximum throughput is one result per 26 ce=1 cycles.
- Reset has priority over ce and start. start=1 in the same cycle as ap_rst=1 is dropped.

## Test plan
- Reset, then 100 / 7 with ce=1 → done exactly 25 edges after accept; quot=14, rem=2, dbz=0; busy high for 25 cycles.
- Sign combinations:
  - −100/7 → −14 r −2
  - 100/−7 → −14 r 2
  - −100/−7 → 14 r −2
  - −2048/−2048 → 1 r 0
- Extremes:
  - −8388608/−1 → quot=0x800000, rem=0
  - 8388607/1 → 0x7FFFFF r 0
  - 5/2047 → 0 r 5
- Divide by zero: 1234/0 → quot=0xFFFFFF, rem=0x4D2, dbz=1. A following 9/3 → 3 r 0 with dbz=0.
- Handshake:
  - start held high, with new operands, throughout an operation → only one result; the next accept occurs on the edge after the done cycle.
  - Random ce with 50% duty → results match golden; latency equals 25 ce=1 edges.
- Reset mid-operation: assert ap_rst at iteration 10 → next cycle busy=0, done=0, quot=0, rem=0. A fresh 50/5 then returns 10 r 0 with no stale done pulse.
